// File: rtl/ascon_serial_host_if.sv
// rtl/ascon_serial_host_if.sv - host request and serial core lanes bundled for ascon_serial_host
interface ascon_serial_host_if #(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 96
);
    logic          start;
    logic          mode;
    logic [K-1:0]  key;
    logic [127:0]  nonce;
    logic [L-1:0]  ad;
    logic [Y-1:0]  pt;
    logic [35:0]   rnd;
    logic [4:0]    key_ser;
    logic [4:0]    nonce_ser;
    logic [4:0]    ad_ser;
    logic [4:0]    pt_ser;
    logic [13:0]   r_64;
    logic [2:0]    r_128;
    logic [2:0]    r_pt;
    logic          enc_start;
    logic          dec_start;
    logic          ct_bit;
    logic          pt_bit;
    logic          tag_bit;
    logic          dec_tag_bit;
    logic          enc_ready;
    logic          dec_ready;
    logic          auth;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [Y-1:0]  data_out;
    logic [127:0]  tag_out;
    logic          auth_out;

    modport master (
        output start, mode, key, nonce, ad, pt, rnd,
        output ct_bit, pt_bit, tag_bit, dec_tag_bit, enc_ready, dec_ready, auth,
        input  key_ser, nonce_ser, ad_ser, pt_ser, r_64, r_128, r_pt,
        input  enc_start, dec_start, busy, done, timeout, data_out, tag_out, auth_out
    );

    modport slave (
        input  start, mode, key, nonce, ad, pt, rnd,
        input  ct_bit, pt_bit, tag_bit, dec_tag_bit, enc_ready, dec_ready, auth,
        output key_ser, nonce_ser, ad_ser, pt_ser, r_64, r_128, r_pt,
        output enc_start, dec_start, busy, done, timeout, data_out, tag_out, auth_out
    );
endinterface

// File: rtl/ascon_serial_host.sv
// rtl/ascon_serial_host.sv - serialises key/nonce/AD/PT into a masked Ascon core and collects its serial results
module ascon_serial_host #(
    parameter int K       = 128,
    parameter int L       = 40,
    parameter int Y       = 96,
    parameter int TIMEOUT = 4096
) (
    input logic            clk,
    input logic            rst,
    ascon_serial_host_if.slave bus
);
    localparam int M1      = (K > L) ? K : L;
    localparam int M2      = (M1 > Y) ? M1 : Y;
    localparam int MAX     = (M2 > 128) ? M2 : 128;
    localparam int CNT_TOP = (MAX > TIMEOUT) ? MAX : TIMEOUT;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [Y-1:0] Y_ONE = Y'(1);
    localparam logic [127:0] T_ONE = 128'(1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP, UNLOAD, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mode_q;
    logic          set_timeout;
    logic          ready_sel;
    logic          cap_data, cap_tag;
    logic [K-1:0]  key_sh;
    logic [127:0]  nonce_sh;
    logic [L-1:0]  ad_sh;
    logic [Y-1:0]  pt_sh;

    // Shifting by the load index puts the current MSB-first bit at the top; indices past a field's width shift in zeros.
    assign key_sh    = bus.key << cnt_nxt;
    assign nonce_sh  = bus.nonce << cnt_nxt;
    assign ad_sh     = bus.ad << cnt_nxt;
    assign pt_sh     = bus.pt << cnt_nxt;

    assign ready_sel = mode_q ? bus.dec_ready : bus.enc_ready;
    assign cap_data  = mode_q ? bus.pt_bit : bus.ct_bit;
    assign cap_tag   = mode_q ? bus.dec_tag_bit : bus.tag_bit;

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.enc_start = (state == START) && !mode_q;
    assign bus.dec_start = (state == START) && mode_q;

    // Next-state and phase counter; the counter restarts at zero on every phase change.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CW'(1);
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.start) begin
                    state_nxt = bus.mode ? START : LOAD;
                end
            end
            LOAD: begin
                if (cnt == CW'(MAX - 1)) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == CW'(4)) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (ready_sel) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    set_timeout = 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(3)) begin
                    state_nxt = UNLOAD;
                    cnt_nxt   = '0;
                end
            end
            UNLOAD: begin
                if (cnt == CW'(MAX - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Mode latch, sticky timeout, result capture and registered serial lanes aligned with the LOAD cycle they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.data_out  <= '0;
            bus.tag_out   <= '0;
            bus.auth_out  <= 1'b0;
            bus.key_ser   <= '0;
            bus.nonce_ser <= '0;
            bus.ad_ser    <= '0;
            bus.pt_ser    <= '0;
            bus.r_64      <= '0;
            bus.r_128     <= '0;
            bus.r_pt      <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                mode_q      <= bus.mode;
                bus.timeout <= 1'b0;
            end
            if (set_timeout) begin
                bus.timeout <= 1'b1;
            end
            if (state == UNLOAD) begin
                bus.data_out <= (bus.data_out & ~(Y_ONE << cnt)) | ({{(Y-1){1'b0}}, cap_data} << cnt);
                bus.tag_out  <= (bus.tag_out & ~(T_ONE << cnt)) | ({127'b0, cap_tag} << cnt);
                if (cnt == CW'(MAX - 1)) begin
                    bus.auth_out <= mode_q & bus.auth;
                end
            end
            if (state_nxt == LOAD) begin
                bus.key_ser   <= {bus.rnd[15:12], key_sh[K-1]};
                bus.ad_ser    <= {bus.rnd[11:8], ad_sh[L-1]};
                bus.pt_ser    <= {bus.rnd[7:4], pt_sh[Y-1]};
                bus.nonce_ser <= {bus.rnd[3:0], nonce_sh[127]};
                bus.r_64      <= bus.rnd[29:16];
                bus.r_pt      <= bus.rnd[32:30];
                bus.r_128     <= bus.rnd[35:33];
            end else begin
                bus.key_ser   <= '0;
                bus.ad_ser    <= '0;
                bus.pt_ser    <= '0;
                bus.nonce_ser <= '0;
                bus.r_64      <= '0;
                bus.r_pt      <= '0;
                bus.r_128     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ascon_serial_host.sv
// tb/tb_ascon_serial_host.sv - scoreboard bench for ascon_serial_host with a behavioural serial core
module tb_ascon_serial_host;
    localparam int K = 128;
    localparam int L = 40;
    localparam int Y = 96;

    localparam logic [127:0] KEY      = 128'h5362006eff0b33bc8bb9950abdb242fc;
    localparam logic [127:0] NONCE    = 128'h1ccfafbc6dc738283ca9fe21ce0fccaa;
    localparam logic [39:0]  AD       = 40'h4153434f4e;
    localparam logic [95:0]  PT       = 96'h48656c6c6f20576f726c6421;
    localparam logic [95:0]  CT_PAT   = 96'hdeadbeef0123456789abcdef;
    localparam logic [127:0] TAG_PAT  = 128'hfeedfacecafef00d13579bdf2468ace0;
    localparam logic [127:0] DTAG_PAT = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    typedef struct {
        logic [Y-1:0] data;
        logic [127:0] tag;
        logic         auth;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_serial_host_if #(.K(K), .L(L), .Y(Y)) bus ();
    ascon_serial_host_if #(.K(K), .L(L), .Y(Y)) bus2 ();

    ascon_serial_host #(.K(K), .L(L), .Y(Y), .TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    ascon_serial_host #(.K(K), .L(L), .Y(Y), .TIMEOUT(16)) dut_to (.clk(clk), .rst(rst), .bus(bus2));

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [127:0] key_v, nonce_v, tag_v, dtag_v;
    logic [39:0]  ad_v;
    logic [95:0]  pt_v, ct_v;
    logic [35:0]  rnd_last;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [35:0] lanes_mask();
        return {bus.r_128, bus.r_pt, bus.r_64, bus.key_ser[4:1], bus.ad_ser[4:1], bus.pt_ser[4:1], bus.nonce_ser[4:1]};
    endfunction

    function automatic logic [3:0] lanes_data();
        return {bus.key_ser[0], bus.nonce_ser[0], bus.ad_ser[0], bus.pt_ser[0]};
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {bus.busy, bus.done, bus.timeout, bus.auth_out, bus.enc_start, bus.dec_start}, 0);
        check({name, "_lanes"}, {lanes_mask(), lanes_data()}, 0);
        check({name, "_data"}, bus.data_out, 0);
        check({name, "_tag"}, bus.tag_out, 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: busy still %b after %0d cycles", name, bus.busy, budget);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 required no pending result");
                end else begin
                    e = sb.pop_front();
                    check("data_out", bus.data_out, e.data);
                    check("tag_out", bus.tag_out, e.tag);
                    check("auth_out", bus.auth_out, e.auth);
                end
            end
            if (bus2.done === 1'b1) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout_done: got done=1 required 0");
            end
        end
    end

    // Behavioural core: ready 30 cycles after start rises, result bit i streamed 5 cycles after ready, one bit per cycle.
    initial begin
        int   k = 0;
        int   idx;
        logic active = 1'b0;
        logic prev_s = 1'b0;
        logic cur_s;
        bus.enc_ready = 1'b0; bus.dec_ready = 1'b0; bus.auth = 1'b1;
        bus.ct_bit = 1'b0; bus.pt_bit = 1'b0; bus.tag_bit = 1'b0; bus.dec_tag_bit = 1'b0;
        forever begin
            @(negedge clk);
            cur_s = bus.enc_start | bus.dec_start;
            if (cur_s && !prev_s) begin
                k = 0;
                active = 1'b1;
                bus.enc_ready = 1'b0;
                bus.dec_ready = 1'b0;
            end else if (active) begin
                k++;
            end
            prev_s = cur_s;
            if (active && k == 30) begin
                bus.enc_ready = 1'b1;
                bus.dec_ready = 1'b1;
            end
            if (active && k >= 35 && k < 35 + 128) begin
                idx = k - 35;
                bus.ct_bit      = (idx < 96) ? ct_v[idx] : 1'b0;
                bus.pt_bit      = (idx < 96) ? pt_v[idx] : 1'b0;
                bus.tag_bit     = tag_v[idx];
                bus.dec_tag_bit = dtag_v[idx];
            end
        end
    end

    initial begin
        logic [3:0] exp_bits;
        key_v = KEY; nonce_v = NONCE; ad_v = AD; pt_v = PT;
        ct_v = CT_PAT; tag_v = TAG_PAT; dtag_v = DTAG_PAT;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.key = '0; bus.nonce = '0; bus.ad = '0; bus.pt = '0; bus.rnd = '0;
        bus2.start = 1'b0; bus2.mode = 1'b0; bus2.key = '0; bus2.nonce = '0; bus2.ad = '0; bus2.pt = '0; bus2.rnd = '0;
        bus2.ct_bit = 1'b0; bus2.pt_bit = 1'b0; bus2.tag_bit = 1'b0; bus2.dec_tag_bit = 1'b0;
        bus2.enc_ready = 1'b0; bus2.dec_ready = 1'b0; bus2.auth = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Encrypt with a stray start/mode=1 pulse during LOAD that must be ignored.
        bus.key = KEY; bus.nonce = NONCE; bus.ad = AD; bus.pt = PT; bus.mode = 1'b0; bus.start = 1'b1;
        rnd_last = 36'({$urandom(), $urandom()});
        bus.rnd = rnd_last;
        sb.push_back('{data: CT_PAT, tag: TAG_PAT, auth: 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        for (int i = 0; i < 128; i++) begin
            if (i > 0) @(negedge clk);
            exp_bits = {key_v[127-i], nonce_v[127-i], (i < 40) ? ad_v[39-i] : 1'b0, (i < 96) ? pt_v[95-i] : 1'b0};
            check($sformatf("load_bits_%0d", i), lanes_data(), exp_bits);
            check($sformatf("load_mask_%0d", i), lanes_mask(), rnd_last);
            rnd_last = 36'({$urandom(), $urandom()});
            bus.rnd = rnd_last;
            if (i == 60) begin bus.start = 1'b1; bus.mode = 1'b1; end
            if (i == 61) begin bus.start = 1'b0; bus.mode = 1'b0; end
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("enc_start_%0d", j), {bus.enc_start, bus.dec_start}, 2'b10);
            check($sformatf("lanes_idle_start_%0d", j), {lanes_mask(), lanes_data()}, 0);
        end
        @(negedge clk);
        check("enc_start_end", {bus.enc_start, bus.dec_start}, 2'b00);
        wait_idle("enc_done", 600);
        check("sb_empty_enc", sb.size(), 0);

        // Decrypt: no LOAD, dec_start for five cycles.
        bus.mode = 1'b1; bus.start = 1'b1;
        sb.push_back('{data: PT, tag: DTAG_PAT, auth: 1'b1});
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check($sformatf("dec_start_%0d", j), {bus.enc_start, bus.dec_start}, 2'b01);
            check($sformatf("dec_no_load_%0d", j), {lanes_mask(), lanes_data()}, 0);
            @(negedge clk);
        end
        check("dec_start_end", {bus.enc_start, bus.dec_start}, 2'b00);
        wait_idle("dec_done", 600);
        check("sb_empty_dec", sb.size(), 0);
        check("no_timeout_main", bus.timeout, 0);

        // Timeout instance: LOAD 128 + START 5 + WAIT 16 cycles, then back to IDLE.
        bus2.mode = 1'b0; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (148) @(negedge clk);
        check("to_busy_last_wait", {bus2.busy, bus2.timeout}, 2'b10);
        @(negedge clk);
        check("to_expired", {bus2.busy, bus2.timeout}, 2'b01);
        repeat (3) @(negedge clk);
        check("to_sticky", {bus2.busy, bus2.timeout}, 2'b01);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        check("to_cleared_by_start", {bus2.busy, bus2.timeout}, 2'b10);

        // Reset in LOAD cycle 50.
        bus.mode = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_rst_load_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_load");
        check("rst_load_dut_to", {bus2.busy, bus2.timeout}, 2'b00);
        @(negedge clk);
        rst = 1'b0; bus.mode = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_after_rst", bus.busy, 1);

        // Reset in UNLOAD (cycle 200 after LOAD begins lies inside UNLOAD 164..291).
        repeat (199) @(negedge clk);
        check("pre_rst_unload_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_unload");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_rst", {bus.busy, bus.done}, 2'b00);
        check("sb_empty_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
